// File: rtl/vexriscv_ram_pkg.sv
// vexriscv_ram_pkg: port B state type, address width and byte-merge helpers for the VexRiscv RAM controller
package vexriscv_ram_pkg;
  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_RD, RMW_WR} portb_state_e;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] mask);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/vexriscv_ram_if.sv
// vexriscv_ram_if: iBus, dBus and loader handshakes between the core side (master) and the RAM controller (slave)
interface vexriscv_ram_if import vexriscv_ram_pkg::*; #(parameter int ADDR_W = addr_w(16384));
  logic ibus_cmd_valid, ibus_cmd_ready, ibus_rsp_valid;
  logic [31:0] ibus_cmd_pc, ibus_rsp_data;
  logic dbus_cmd_valid, dbus_cmd_ready, dbus_cmd_wr, dbus_rsp_valid;
  logic [31:0] dbus_cmd_addr, dbus_cmd_data, dbus_rsp_data;
  logic [3:0] dbus_cmd_mask;
  logic ld_valid, ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0] ld_data;
  modport master(
    output ibus_cmd_valid, ibus_cmd_pc, dbus_cmd_valid, dbus_cmd_wr, dbus_cmd_addr, dbus_cmd_data, dbus_cmd_mask,
           ld_valid, ld_addr, ld_data,
    input  ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_data, dbus_cmd_ready, dbus_rsp_valid, dbus_rsp_data, ld_ready
  );
  modport slave(
    input  ibus_cmd_valid, ibus_cmd_pc, dbus_cmd_valid, dbus_cmd_wr, dbus_cmd_addr, dbus_cmd_data, dbus_cmd_mask,
           ld_valid, ld_addr, ld_data,
    output ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_data, dbus_cmd_ready, dbus_rsp_valid, dbus_rsp_data, ld_ready
  );
endinterface

// File: rtl/vexriscv_ram_rsp_pipe.sv
// vexriscv_ram_rsp_pipe: LAT-deep valid delay line matching the RAM read latency (ports clk, rst, in_valid -> out_valid)
module vexriscv_ram_rsp_pipe #(parameter int LAT = 2) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic out_valid
);
  logic [LAT-1:0] sr;
  always_ff @(posedge clk) sr <= rst ? '0 : LAT'({sr, in_valid});
  assign out_valid = sr[LAT-1];
endmodule

// File: rtl/vexriscv_ram_ctrl.sv
// vexriscv_ram_ctrl: dual-port BRAM sequencer (port A iBus fetch, port B dBus with RMW byte writes; loader arbitration when VEXRISCV_RAM_LOADER_EN) - ports clk, rst, bus (slave), ram_* BRAM pins
module vexriscv_ram_ctrl import vexriscv_ram_pkg::*; #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 16384,
  parameter int RAM_LATENCY = 2,
  localparam int ADDR_W = addr_w(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  vexriscv_ram_if.slave        bus,
  output logic                 ram_ena,
  output logic                 ram_enb,
  output logic                 ram_wea,
  output logic                 ram_web,
  output logic [ADDR_W-1:0]    ram_addra,
  output logic [ADDR_W-1:0]    ram_addrb,
  output logic [RAM_WIDTH-1:0] ram_dina,
  output logic [RAM_WIDTH-1:0] ram_dinb,
  output logic                 ram_regcea,
  output logic                 ram_regceb,
  output logic                 ram_rsta,
  output logic                 ram_rstb,
  input  logic [RAM_WIDTH-1:0] ram_douta,
  input  logic [RAM_WIDTH-1:0] ram_doutb
);
  portb_state_e state;
  logic [1:0] cnt;
  logic [ADDR_W-1:0] lat_addr, pc_word, d_word;
  logic [31:0] lat_data;
  logic [3:0] lat_mask;
  logic idle, wr_st, ld_go, d_acc, d_rd, d_full, d_part, wait_done;
  logic unused_bits;
  assign pc_word = bus.ibus_cmd_pc[ADDR_W+1:2];
  assign d_word = bus.dbus_cmd_addr[ADDR_W+1:2];
  assign unused_bits = ^{bus.ibus_cmd_pc[31:ADDR_W+2], bus.ibus_cmd_pc[1:0], bus.dbus_cmd_addr[31:ADDR_W+2], bus.dbus_cmd_addr[1:0]};
  assign idle = !rst && state == IDLE;
  assign wr_st = !rst && state == RMW_WR;
`ifdef VEXRISCV_RAM_LOADER_EN
  assign ld_go = idle && bus.ld_valid;
`else
  logic unused_ld;
  assign unused_ld = bus.ld_valid;
  assign ld_go = 1'b0;
`endif
  assign bus.ld_ready = ld_go;
  assign bus.dbus_cmd_ready = idle && !ld_go;
  assign d_acc = bus.dbus_cmd_valid && bus.dbus_cmd_ready;
  assign d_rd = d_acc && !bus.dbus_cmd_wr;
  assign d_full = d_acc && bus.dbus_cmd_wr && bus.dbus_cmd_mask == 4'hF;
  assign d_part = d_acc && bus.dbus_cmd_wr && bus.dbus_cmd_mask != 4'hF && bus.dbus_cmd_mask != 4'h0;
  assign wait_done = cnt == 2'(RAM_LATENCY - 1);
  assign ram_enb = ld_go || d_rd || d_full || d_part || wr_st;
  assign ram_web = ld_go || d_full || wr_st;
  assign ram_addrb = wr_st ? lat_addr : ld_go ? bus.ld_addr : d_word;
  assign ram_dinb = wr_st ? lat_data : ld_go ? bus.ld_data : bus.dbus_cmd_data;
  // a fetch of the word port B is writing this cycle is held off so the RAM never sees a same-address read/write
  assign bus.ibus_cmd_ready = !rst && !(ram_web && ram_addrb == pc_word);
  assign ram_ena = bus.ibus_cmd_valid && bus.ibus_cmd_ready;
  assign ram_wea = 1'b0;
  assign ram_addra = pc_word;
  assign ram_dina = '0;
  assign ram_regcea = 1'b1;
  assign ram_regceb = 1'b1;
  assign ram_rsta = rst;
  assign ram_rstb = rst;
  assign bus.ibus_rsp_data = ram_douta;
  assign bus.dbus_rsp_data = ram_doutb;
  vexriscv_ram_rsp_pipe #(.LAT(RAM_LATENCY)) u_pipe_a (.clk(clk), .rst(rst), .in_valid(ram_ena), .out_valid(bus.ibus_rsp_valid));
  vexriscv_ram_rsp_pipe #(.LAT(RAM_LATENCY)) u_pipe_b (.clk(clk), .rst(rst), .in_valid(d_rd), .out_valid(bus.dbus_rsp_valid));
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      cnt <= (state == IDLE || wait_done) ? '0 : cnt + 2'd1;
      case (state)
        IDLE:    state <= d_rd ? RD_WAIT : d_part ? RMW_RD : IDLE;
        RD_WAIT: state <= wait_done ? IDLE : RD_WAIT;
        RMW_RD:  state <= wait_done ? RMW_WR : RMW_RD;
        default: state <= IDLE;
      endcase
      if (d_part) begin
        lat_addr <= d_word;
        lat_data <= bus.dbus_cmd_data;
        lat_mask <= bus.dbus_cmd_mask;
      end
      // old word is on ram_doutb exactly when the latency count expires
      if (state == RMW_RD && wait_done) lat_data <= byte_merge(ram_doutb, lat_data, lat_mask);
    end
endmodule

// File: tb/tb_vexriscv_ram_ctrl.sv
// tb_vexriscv_ram_ctrl: randomized self-checking bench with a 2-cycle BRAM model and a word-level reference memory
`timescale 1ns/1ps
module tb_vexriscv_ram_ctrl;
  localparam int AW = 14;
  localparam int DEPTH = 16384;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  vexriscv_ram_if #(.ADDR_W(AW)) bus();
  logic ram_ena, ram_enb, ram_wea, ram_web, ram_regcea, ram_regceb, ram_rsta, ram_rstb;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [31:0] ram_dina, ram_dinb, ram_douta, ram_doutb;
  vexriscv_ram_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_ena(ram_ena), .ram_enb(ram_enb), .ram_wea(ram_wea), .ram_web(ram_web),
    .ram_addra(ram_addra), .ram_addrb(ram_addrb), .ram_dina(ram_dina), .ram_dinb(ram_dinb),
    .ram_regcea(ram_regcea), .ram_regceb(ram_regceb), .ram_rsta(ram_rsta), .ram_rstb(ram_rstb),
    .ram_douta(ram_douta), .ram_doutb(ram_doutb)
  );
  // BRAM with an output register: data appears two edges after the address
  logic [31:0] mem [DEPTH];
  logic [31:0] a_s1, b_s1;
  always @(posedge clk) begin
    if (ram_ena) begin
      if (ram_wea) mem[ram_addra] <= ram_dina;
      a_s1 <= mem[ram_addra];
    end
    if (ram_enb) begin
      if (ram_web) mem[ram_addrb] <= ram_dinb;
      b_s1 <= mem[ram_addrb];
    end
    ram_douta <= ram_rsta ? '0 : ram_regcea ? a_s1 : ram_douta;
    ram_doutb <= ram_rstb ? '0 : ram_regceb ? b_s1 : ram_doutb;
  end
  logic [31:0] ref_mem [DEPTH];
  int checks = 0;
  int failures = 0;
  function automatic logic [31:0] byte_addr(input logic [AW-1:0] w);
    logic [31:0] r;
    r = $urandom;
    return {r[31:AW+2], w, r[1:0]};
  endfunction
  function automatic logic [31:0] merge_ref(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
    logic [31:0] bm;
    bm = '0;
    for (int i = 0; i < 4; i++) if (m[i]) bm = bm | (32'hFF << (8 * i));
    return (o & ~bm) | (n & bm);
  endfunction
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs;
    bus.ibus_cmd_valid = 0; bus.ibus_cmd_pc = 0;
    bus.dbus_cmd_valid = 0; bus.dbus_cmd_wr = 0; bus.dbus_cmd_addr = 0; bus.dbus_cmd_data = 0; bus.dbus_cmd_mask = 0;
    bus.ld_valid = 0; bus.ld_addr = 0; bus.ld_data = 0;
  endtask
  task automatic dbus_write(input logic [AW-1:0] w, input logic [31:0] d, input logic [3:0] m, output bit ok);
    ok = 0;
    bus.dbus_cmd_valid = 1; bus.dbus_cmd_wr = 1; bus.dbus_cmd_addr = byte_addr(w);
    bus.dbus_cmd_data = d; bus.dbus_cmd_mask = m;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.dbus_cmd_ready;
      next_cycle;
    end
    bus.dbus_cmd_valid = 0;
  endtask
  task automatic dbus_read(input logic [AW-1:0] w, output logic [31:0] d, output int lat);
    bit acc;
    acc = 0; lat = -1; d = '0;
    bus.dbus_cmd_valid = 1; bus.dbus_cmd_wr = 0; bus.dbus_cmd_addr = byte_addr(w); bus.dbus_cmd_mask = 4'h0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = bus.dbus_cmd_ready;
      next_cycle;
    end
    bus.dbus_cmd_valid = 0;
    if (!acc) return;
    for (int n = 1; n <= 10 && lat < 0; n++) begin
      @(negedge clk);
      if (bus.dbus_rsp_valid) begin d = bus.dbus_rsp_data; lat = n; end
      next_cycle;
    end
  endtask
  task automatic preload(input logic [AW-1:0] w, input logic [31:0] d);
    bit ok;
    dbus_write(w, d, 4'hF, ok);
    ref_mem[w] = d;
    checks++;
    if (!ok) begin failures++; $display("FAIL preload_accept word=%0d got=timeout required=accept", w); end
  endtask
  task automatic test_reset;
    rst = 1;
    bus.ibus_cmd_valid = 1; bus.dbus_cmd_valid = 1; bus.dbus_cmd_wr = 1; bus.dbus_cmd_mask = 4'hF; bus.ld_valid = 1;
    next_cycle; next_cycle;
    @(negedge clk);
    checks++;
    if ({bus.ibus_cmd_ready, bus.dbus_cmd_ready, bus.ld_ready, ram_ena, ram_enb, ram_web, bus.ibus_rsp_valid, bus.dbus_rsp_valid} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=00000000", {bus.ibus_cmd_ready, bus.dbus_cmd_ready, bus.ld_ready, ram_ena, ram_enb, ram_web, bus.ibus_rsp_valid, bus.dbus_rsp_valid});
    end
    checks++;
    if ({ram_regcea, ram_regceb, ram_rsta, ram_rstb} !== 4'hF) begin failures++; $display("FAIL reset_ram_ctl got=%b required=1111", {ram_regcea, ram_regceb, ram_rsta, ram_rstb}); end
    clear_inputs;
    next_cycle;
    rst = 0;
    next_cycle;
    @(negedge clk);
    checks++;
    if ({bus.ibus_cmd_ready, bus.dbus_cmd_ready, bus.ld_ready, ram_rstb} !== 4'b1100) begin failures++; $display("FAIL post_reset_ready got=%b required=1100", {bus.ibus_cmd_ready, bus.dbus_cmd_ready, bus.ld_ready, ram_rstb}); end
    next_cycle;
  endtask
  task automatic test_fetch_burst;
    for (int i = 0; i < 8; i++) preload(AW'(i), $urandom);
    for (int k = 0; k < 12; k++) begin
      bus.ibus_cmd_valid = k < 8;
      bus.ibus_cmd_pc = byte_addr(AW'(k));
      @(negedge clk);
      if (k < 8) begin
        checks++;
        if (bus.ibus_cmd_ready !== 1'b1) begin failures++; $display("FAIL burst_ready k=%0d got=%b required=1", k, bus.ibus_cmd_ready); end
      end
      checks++;
      if (k >= 2 && k < 10) begin
        if (bus.ibus_rsp_valid !== 1'b1 || bus.ibus_rsp_data !== ref_mem[k-2])
          begin failures++; $display("FAIL burst_rsp k=%0d got=%b/%h required=1/%h", k, bus.ibus_rsp_valid, bus.ibus_rsp_data, ref_mem[k-2]); end
      end else if (bus.ibus_rsp_valid !== 1'b0) begin
        failures++; $display("FAIL burst_idle k=%0d got=%b required=0", k, bus.ibus_rsp_valid);
      end
      next_cycle;
    end
    clear_inputs;
  endtask
  task automatic test_fetch_random;
    logic [AW-1:0] wl [6];
    logic [31:0] q_data [$];
    int q_cyc [$];
    int sent, idx, ec;
    logic [31:0] ed;
    for (int i = 0; i < 6; i++) begin
      wl[i] = AW'($urandom_range(DEPTH - 1, 8));
      preload(wl[i], $urandom);
    end
    sent = 0;
    for (int k = 0; k < 80 && (sent < 12 || q_data.size() > 0); k++) begin
      idx = $urandom_range(0, 5);
      bus.ibus_cmd_valid = sent < 12 && $urandom_range(0, 1) == 1;
      bus.ibus_cmd_pc = byte_addr(wl[idx]);
      @(negedge clk);
      if (bus.ibus_rsp_valid) begin
        checks++;
        if (q_data.size() == 0) begin
          failures++; $display("FAIL fetch_rand_spurious k=%0d got=rsp required=none", k);
        end else begin
          ed = q_data.pop_front();
          ec = q_cyc.pop_front();
          if (bus.ibus_rsp_data !== ed || k != ec + 2)
            begin failures++; $display("FAIL fetch_rand_rsp got=%h@%0d required=%h@%0d", bus.ibus_rsp_data, k, ed, ec + 2); end
        end
      end
      if (bus.ibus_cmd_valid && bus.ibus_cmd_ready) begin
        q_data.push_back(ref_mem[wl[idx]]);
        q_cyc.push_back(k);
        sent++;
      end
      next_cycle;
    end
    clear_inputs;
    checks++;
    if (sent != 12 || q_data.size() != 0) begin failures++; $display("FAIL fetch_rand_drain got=sent%0d/pending%0d required=sent12/pending0", sent, q_data.size()); end
  endtask
  task automatic test_rmw;
    logic [AW-1:0] w;
    logic [31:0] expd, d, rd;
    logic [3:0] m;
    int lat;
    bit ok;
    w = AW'($urandom_range(DEPTH - 1, 8));
    preload(w, 32'h11223344);
    expd = merge_ref(32'h11223344, 32'hDEADBEEF, 4'h3);
    bus.dbus_cmd_valid = 1; bus.dbus_cmd_wr = 1; bus.dbus_cmd_addr = byte_addr(w);
    bus.dbus_cmd_data = 32'hDEADBEEF; bus.dbus_cmd_mask = 4'h3;
    @(negedge clk);
    checks++;
    if (bus.dbus_cmd_ready !== 1'b1) begin failures++; $display("FAIL rmw_accept got=%b required=1", bus.dbus_cmd_ready); end
    next_cycle;
    clear_inputs;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.dbus_cmd_ready !== (k == 4)) begin failures++; $display("FAIL rmw_ready k=%0d got=%b required=%b", k, bus.dbus_cmd_ready, k == 4); end
      checks++;
      if (k == 3) begin
        if (ram_web !== 1'b1 || ram_addrb !== w || ram_dinb !== expd)
          begin failures++; $display("FAIL rmw_write got=%b/%h/%h required=1/%h/%h", ram_web, ram_addrb, ram_dinb, w, expd); end
      end else if (ram_web !== 1'b0) begin
        failures++; $display("FAIL rmw_no_write k=%0d got=%b required=0", k, ram_web);
      end
      next_cycle;
    end
    ref_mem[w] = expd;
    dbus_read(w, rd, lat);
    checks++;
    if (rd !== 32'h1122BEEF || lat != 2) begin failures++; $display("FAIL rmw_readback got=%h@%0d required=1122beef@2", rd, lat); end
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      m = 4'($urandom);
      dbus_write(w, d, m, ok);
      ref_mem[w] = merge_ref(ref_mem[w], d, m);
      dbus_read(w, rd, lat);
      checks++;
      if (!ok || rd !== ref_mem[w] || lat != 2)
        begin failures++; $display("FAIL rand_mask_write mask=%h got=%h@%0d required=%h@2", m, rd, lat, ref_mem[w]); end
    end
  endtask
  task automatic test_full_write_read;
    logic [AW-1:0] w;
    logic [31:0] rd;
    int lat;
    w = AW'($urandom_range(DEPTH - 1, 8));
    preload(w, 32'hA5A5A5A5);
    dbus_read(w, rd, lat);
    checks++;
    if (rd !== 32'hA5A5A5A5 || lat != 2) begin failures++; $display("FAIL full_write_read got=%h@%0d required=a5a5a5a5@2", rd, lat); end
  endtask
  task automatic test_collision;
    logic [AW-1:0] w;
    logic [31:0] nd;
    w = AW'($urandom_range(DEPTH - 1, 8));
    preload(w, $urandom);
    nd = $urandom;
    bus.ibus_cmd_valid = 1; bus.ibus_cmd_pc = byte_addr(w);
    bus.dbus_cmd_valid = 1; bus.dbus_cmd_wr = 1; bus.dbus_cmd_addr = byte_addr(w); bus.dbus_cmd_data = nd; bus.dbus_cmd_mask = 4'hF;
    @(negedge clk);
    checks++;
    if ({bus.ibus_cmd_ready, ram_ena, bus.dbus_cmd_ready} !== 3'b001) begin failures++; $display("FAIL collision_block got=%b required=001", {bus.ibus_cmd_ready, ram_ena, bus.dbus_cmd_ready}); end
    next_cycle;
    ref_mem[w] = nd;
    bus.dbus_cmd_valid = 0;
    @(negedge clk);
    checks++;
    if (bus.ibus_cmd_ready !== 1'b1) begin failures++; $display("FAIL collision_retry got=%b required=1", bus.ibus_cmd_ready); end
    next_cycle;
    bus.ibus_cmd_valid = 0;
    @(negedge clk);
    next_cycle;
    @(negedge clk);
    checks++;
    if (bus.ibus_rsp_valid !== 1'b1 || bus.ibus_rsp_data !== nd) begin failures++; $display("FAIL collision_data got=%b/%h required=1/%h", bus.ibus_rsp_valid, bus.ibus_rsp_data, nd); end
    next_cycle;
    bus.ibus_cmd_valid = 1; bus.ibus_cmd_pc = byte_addr(w);
    bus.dbus_cmd_valid = 1; bus.dbus_cmd_wr = 1; bus.dbus_cmd_addr = byte_addr(w ^ AW'(1)); bus.dbus_cmd_data = nd; bus.dbus_cmd_mask = 4'hF;
    @(negedge clk);
    checks++;
    if (bus.ibus_cmd_ready !== 1'b1) begin failures++; $display("FAIL no_collision_ready got=%b required=1", bus.ibus_cmd_ready); end
    next_cycle;
    ref_mem[w ^ AW'(1)] = nd;
    clear_inputs;
    next_cycle; next_cycle;
  endtask
  task automatic test_loader;
    logic [AW-1:0] a1, a2;
    logic [31:0] d1, d2, rd;
    int lat;
    a1 = AW'($urandom_range(DEPTH - 1, 8));
    a2 = a1 ^ AW'(1);
    preload(a1, $urandom);
    preload(a2, $urandom);
    d1 = $urandom; d2 = $urandom;
    bus.ld_valid = 1; bus.ld_addr = a1; bus.ld_data = d1;
    bus.dbus_cmd_valid = 1; bus.dbus_cmd_wr = 1; bus.dbus_cmd_addr = byte_addr(a2); bus.dbus_cmd_data = d2; bus.dbus_cmd_mask = 4'hF;
    @(negedge clk);
`ifdef VEXRISCV_RAM_LOADER_EN
    checks++;
    if ({bus.ld_ready, bus.dbus_cmd_ready} !== 2'b10) begin failures++; $display("FAIL loader_first got=%b required=10", {bus.ld_ready, bus.dbus_cmd_ready}); end
    next_cycle;
    ref_mem[a1] = d1;
    bus.ld_valid = 0;
    @(negedge clk);
    checks++;
    if (bus.dbus_cmd_ready !== 1'b1) begin failures++; $display("FAIL dbus_after_loader got=%b required=1", bus.dbus_cmd_ready); end
`else
    checks++;
    if ({bus.ld_ready, bus.dbus_cmd_ready} !== 2'b01) begin failures++; $display("FAIL loader_disabled got=%b required=01", {bus.ld_ready, bus.dbus_cmd_ready}); end
`endif
    next_cycle;
    ref_mem[a2] = d2;
    clear_inputs;
    dbus_read(a1, rd, lat);
    checks++;
    if (rd !== ref_mem[a1] || lat != 2) begin failures++; $display("FAIL loader_word got=%h@%0d required=%h@2", rd, lat, ref_mem[a1]); end
    dbus_read(a2, rd, lat);
    checks++;
    if (rd !== ref_mem[a2] || lat != 2) begin failures++; $display("FAIL loader_dbus_word got=%h@%0d required=%h@2", rd, lat, ref_mem[a2]); end
  endtask
  task automatic test_rst_in_rmw;
    logic [AW-1:0] w;
    logic [31:0] rd;
    int lat;
    w = AW'($urandom_range(DEPTH - 1, 8));
    preload(w, $urandom);
    bus.dbus_cmd_valid = 1; bus.dbus_cmd_wr = 1; bus.dbus_cmd_addr = byte_addr(w);
    bus.dbus_cmd_data = ~ref_mem[w]; bus.dbus_cmd_mask = 4'h6;
    @(negedge clk);
    checks++;
    if (bus.dbus_cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_rmw_accept got=%b required=1", bus.dbus_cmd_ready); end
    next_cycle;
    clear_inputs;
    rst = 1;
    @(negedge clk);
    checks++;
    if ({ram_web, ram_enb, bus.dbus_cmd_ready} !== 3'b000) begin failures++; $display("FAIL rst_rmw_hold got=%b required=000", {ram_web, ram_enb, bus.dbus_cmd_ready}); end
    next_cycle;
    rst = 0;
    @(negedge clk);
    checks++;
    if ({ram_web, ram_enb, ram_ena, bus.ibus_rsp_valid, bus.dbus_rsp_valid, bus.ld_ready, bus.dbus_cmd_ready} !== 7'b0000001)
      begin failures++; $display("FAIL rst_rmw_after got=%b required=0000001", {ram_web, ram_enb, ram_ena, bus.ibus_rsp_valid, bus.dbus_rsp_valid, bus.ld_ready, bus.dbus_cmd_ready}); end
    for (int k = 0; k < 3; k++) begin
      next_cycle;
      @(negedge clk);
      checks++;
      if (ram_web !== 1'b0) begin failures++; $display("FAIL rst_rmw_late_write k=%0d got=%b required=0", k, ram_web); end
    end
    next_cycle;
    dbus_read(w, rd, lat);
    checks++;
    if (rd !== ref_mem[w] || lat != 2) begin failures++; $display("FAIL rst_rmw_unchanged got=%h@%0d required=%h@2", rd, lat, ref_mem[w]); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    clear_inputs;
    test_reset;
    test_fetch_burst;
    test_fetch_random;
    test_rmw;
    test_full_write_read;
    test_collision;
    test_loader;
    test_rst_in_rmw;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
